// File: rtl/ex_pkg.sv
// Shared constants and types for the execute stage.
// EX_DIV_EN enables the iterative DIV/DIVU path in iter_muldiv and ex_stage.
package ex_pkg;

  localparam int DEF_MUL_CYCLES = 32;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_ADDI  = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_SLT, ALU_HI, ALU_LO, ALU_NONE
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE, BUSY, DIV_BUSY
  } md_state_t;

  typedef enum logic [1:0] {
    MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  } md_op_t;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative 32-step multiplier (and divider with EX_DIV_EN) owning HI/LO.
// EX_DIV_EN adds restoring division in state DIV_BUSY.
module iter_muldiv
  import ex_pkg::*;
#(
  parameter int CYCLES = DEF_MUL_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  md_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [63:0] acc, mcand, acc_nx, prod;
  logic [31:0] mplier, ma, mb;
  logic        neg, sgn, last;

  assign sgn  = (op == MD_MULT) || (op == MD_DIV);
  assign ma   = mag(a, sgn);
  assign mb   = mag(b, sgn);
  assign last = (cnt == LAST);

  assign acc_nx = acc + (mplier[0] ? mcand : 64'd0);
  assign prod   = neg ? -acc_nx : acc_nx;

`ifdef EX_DIV_EN
  logic        rneg, dz, is_div;
  logic [32:0] dsh, ddf;
  logic [63:0] div_nx;

  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  // acc holds {remainder, dividend/quotient}; mplier holds the divisor
  assign dsh    = {acc[63:32], acc[31]};
  assign ddf    = dsh - {1'b0, mplier};
  assign div_nx = ddf[32] ? {dsh[31:0], acc[30:0], 1'b0}
                          : {ddf[31:0], acc[30:0], 1'b1};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
`ifdef EX_DIV_EN
          state_nx = is_div ? DIV_BUSY : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY, DIV_BUSY: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef EX_DIV_EN
      rneg   <= 1'b0;
      dz     <= 1'b0;
`endif
    end else if (start && state == IDLE) begin
      cnt    <= '0;
      mplier <= mb;
      neg    <= sgn && (a[31] ^ b[31]);
`ifdef EX_DIV_EN
      rneg   <= sgn && a[31];
      dz     <= (b == 32'd0);
      acc    <= is_div ? {32'd0, ma} : 64'd0;
      mcand  <= is_div ? 64'd0 : {32'd0, ma};
`else
      acc    <= '0;
      mcand  <= {32'd0, ma};
`endif
    end else if (state == BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) {hi, lo} <= prod;
`ifdef EX_DIV_EN
    end else if (state == DIV_BUSY) begin
      acc <= div_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        hi <= rneg ? -div_nx[63:32] : div_nx[63:32];
        lo <= dz  ? 32'hFFFF_FFFF
            : neg ? -div_nx[31:0] : div_nx[31:0];
      end
`endif
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, ALU control, branch adder, rd mux, EX/MEM latch.
// EX_DIV_EN adds DIV/DIVU issue and stall decode.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic [3:0]  ex_ctl,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic        ex_stall,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  muxout
);

  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] opb, res, hi, lo;
  logic        busy, md_go, dep, start;
  alu_op_t     alu_op;
  md_op_t      md_op;

  assign aluop = ex_ctl[2:1];
  assign funct = s_extend[5:0];
  assign opb   = ex_ctl[0] ? s_extend : rdata2;

  always_comb begin
    alu_op = ALU_NONE;
    md_go  = 1'b0;
    md_op  = MD_MULT;
    dep    = 1'b0;
    unique case (1'b1)
      aluop == AOP_ADD,
      aluop == AOP_ADDI: alu_op = ALU_ADD;
      aluop == AOP_SUB:  alu_op = ALU_SUB;
      default: begin
        unique case (1'b1)
          funct == F_ADD:  alu_op = ALU_ADD;
          funct == F_SUB:  alu_op = ALU_SUB;
          funct == F_AND:  alu_op = ALU_AND;
          funct == F_OR:   alu_op = ALU_OR;
          funct == F_SLT:  alu_op = ALU_SLT;
          funct == F_MFHI: begin alu_op = ALU_HI; dep = 1'b1; end
          funct == F_MFLO: begin alu_op = ALU_LO; dep = 1'b1; end
          funct == F_MULT: begin
            md_go = 1'b1; dep = 1'b1; md_op = MD_MULT;
          end
          funct == F_MULTU: begin
            md_go = 1'b1; dep = 1'b1; md_op = MD_MULTU;
          end
`ifdef EX_DIV_EN
          funct == F_DIV: begin
            md_go = 1'b1; dep = 1'b1; md_op = MD_DIV;
          end
          funct == F_DIVU: begin
            md_go = 1'b1; dep = 1'b1; md_op = MD_DIVU;
          end
`endif
          default: alu_op = ALU_NONE;
        endcase
      end
    endcase
  end

  always_comb begin
    res = '0;
    unique case (alu_op)
      ALU_ADD: res = rdata1 + opb;
      ALU_SUB: res = rdata1 - opb;
      ALU_AND: res = rdata1 & opb;
      ALU_OR:  res = rdata1 | opb;
      ALU_SLT: res = {31'd0, $signed(rdata1) < $signed(opb)};
      ALU_HI:  res = hi;
      ALU_LO:  res = lo;
      default: res = '0;
    endcase
  end

  assign ex_stall = busy & dep;
  assign start    = md_go & ~ex_stall;

  iter_muldiv #(
    .CYCLES (MUL_CYCLES)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (md_op),
    .a     (rdata1),
    .b     (rdata2),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // A stalled edge inserts a bubble: control drops, data holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
    end else if (ex_stall) begin
      wb_ctlout <= '0;
      m_ctlout  <= '0;
    end else begin
      wb_ctlout  <= md_go ? 2'b00 : wb_ctl;
      m_ctlout   <= md_go ? 3'b000 : m_ctl;
      add_result <= npc + (s_extend << 2);
      zero       <= (res == 32'd0);
      alu_result <= res;
      rdata2out  <= rdata2;
      muxout     <= ex_ctl[3] ? instr_1511 : instr_2016;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Build with EX_DIV_EN to include the divide vectors.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [4:0]  instr_2016, instr_1511;
  logic        ex_stall;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result, alu_result, rdata2out;
  logic        zero;
  logic [4:0]  muxout;

  int errors = 0;
  int checks = 0;
  int n;
  logic bub_bad;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .reset      (reset),
    .wb_ctl     (wb_ctl),
    .m_ctl      (m_ctl),
    .ex_ctl     (ex_ctl),
    .npc        (npc),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .s_extend   (s_extend),
    .instr_2016 (instr_2016),
    .instr_1511 (instr_1511),
    .ex_stall   (ex_stall),
    .wb_ctlout  (wb_ctlout),
    .m_ctlout   (m_ctlout),
    .add_result (add_result),
    .zero       (zero),
    .alu_result (alu_result),
    .rdata2out  (rdata2out),
    .muxout     (muxout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    ex_ctl   = 4'b1100;
    wb_ctl   = 2'b10;
    m_ctl    = 3'b000;
    s_extend = {26'd0, f};
    rdata1   = a;
    rdata2   = b;
  endtask

  task automatic wait_free();
    n = 0;
    while (ex_stall && n < 40) begin
      step();
      n++;
    end
    chk("stall_bound", {31'd0, ex_stall}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    wb_ctl = 0; m_ctl = 0; ex_ctl = 0;
    npc = 0; rdata1 = 0; rdata2 = 0; s_extend = 0;
    instr_2016 = 0; instr_1511 = 0;
    #12;
    chk("rst_alu", alu_result, 0);
    chk("rst_wb", {30'd0, wb_ctlout}, 0);
    chk("rst_stall", {31'd0, ex_stall}, 0);
    reset = 1'b1;

    // R-type add
    rtype(6'h20, 5, 7);
    instr_1511 = 3;
    step();
    chk("add_res", alu_result, 12);
    chk("add_zero", {31'd0, zero}, 0);
    chk("add_mux", {27'd0, muxout}, 3);
    chk("add_wb", {30'd0, wb_ctlout}, 2);

    // branch compare
    ex_ctl = 4'b0010; wb_ctl = 0; m_ctl = 3'b100;
    npc = 32'h100; s_extend = 4; rdata1 = 9; rdata2 = 9;
    step();
    chk("br_target", add_result, 32'h110);
    chk("br_zero", {31'd0, zero}, 1);
    chk("br_m", {29'd0, m_ctlout}, 4);

    // slt signed
    rtype(6'h2A, 32'hFFFF_FFFE, 1);
    step();
    chk("slt", alu_result, 1);

    // signed multiply then MFLO/MFHI
    rtype(6'h18, 32'hFFFF_FFFD, 7);
    #1;
    chk("mult_nostall", {31'd0, ex_stall}, 0);
    step();
    chk("mult_wb0", {30'd0, wb_ctlout}, 0);
    rtype(6'h12, 0, 0);
    instr_1511 = 5;
    #1;
    chk("mflo_stall", {31'd0, ex_stall}, 1);
    n = 0;
    bub_bad = 1'b0;
    while (ex_stall && n < 40) begin
      step();
      n++;
      if (wb_ctlout !== 2'b00) bub_bad = 1'b1;
    end
    chk("stall_cycles", n, 32);
    chk("bubbles", {31'd0, bub_bad}, 0);
    step();
    chk("mflo", alu_result, 32'hFFFF_FFEB);
    chk("mflo_wb", {30'd0, wb_ctlout}, 2);
    chk("mflo_mux", {27'd0, muxout}, 5);
    rtype(6'h10, 0, 0);
    step();
    chk("mfhi", alu_result, 32'hFFFF_FFFF);

    // independent op while busy
    rtype(6'h19, 32'hFFFF_FFFF, 2);
    step();
    rtype(6'h25, 32'hF0, 32'h0F);
    #1;
    chk("or_nostall", {31'd0, ex_stall}, 0);
    step();
    chk("or_res", alu_result, 32'hFF);
    rtype(6'h10, 0, 0);
    #1;
    wait_free();
    step();
    chk("multu_hi", alu_result, 1);
    rtype(6'h12, 0, 0);
    step();
    chk("multu_lo", alu_result, 32'hFFFF_FFFE);

    // reset mid-multiply
    rtype(6'h18, 5, 5);
    npc = 32'h200;
    step();
    chk("mul2_target", add_result, 32'h260);
    rtype(6'h10, 0, 0);
    #1;
    chk("busy_stall", {31'd0, ex_stall}, 1);
    repeat (9) step();
    reset = 1'b0;
    #1;
    chk("mrst_target", add_result, 0);
    chk("mrst_mux", {27'd0, muxout}, 0);
    chk("mrst_stall", {31'd0, ex_stall}, 0);
    #2;
    reset = 1'b1;
    step();
    chk("mrst_hi", alu_result, 0);
    rtype(6'h12, 0, 0);
    step();
    chk("mrst_lo", alu_result, 0);

    // unknown funct
    rtype(6'h3F, 3, 4);
    step();
    chk("unk_res", alu_result, 0);
    chk("unk_zero", {31'd0, zero}, 1);

`ifdef EX_DIV_EN
    rtype(6'h1A, 32'hFFFF_FFF9, 2);
    step();
    rtype(6'h12, 0, 0);
    #1;
    wait_free();
    step();
    chk("div_lo", alu_result, 32'hFFFF_FFFD);
    rtype(6'h10, 0, 0);
    step();
    chk("div_hi", alu_result, 32'hFFFF_FFFF);
    rtype(6'h1B, 5, 0);
    step();
    rtype(6'h12, 0, 0);
    #1;
    wait_free();
    chk("divz_cycles", n, 32);
    step();
    chk("divz_lo", alu_result, 32'hFFFF_FFFF);
    rtype(6'h10, 0, 0);
    step();
    chk("divz_hi", alu_result, 5);
`else
    rtype(6'h1A, 7, 2);
    step();
    rtype(6'h10, 0, 0);
    #1;
    chk("nodiv_stall", {31'd0, ex_stall}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
